// File: rtl/clk_req_arbiter.sv
// Round-robin arbiter: one-hot registered grant, one-cycle idle gap between owners.
// Optional hold timeout enabled by defining CLK_REQ_ARBITER_TIMEOUT_EN.
module clk_req_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_done,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id,
  output logic             o_busy,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_ptr;
  logic             r_busy;

  logic [ID_W-1:0]  w_sel;
  logic [N_REQ-1:0] w_onehot;
  logic             w_rel;

  // Descending scan so the nearest requester after r_ptr wins.
  always_comb begin
    w_sel = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (i_req[ID_W'((int'(r_ptr) + i) % N_REQ)])
        w_sel = ID_W'((int'(r_ptr) + i) % N_REQ);
    end
  end

  assign w_onehot = ONE << w_sel;
  assign w_rel    = (|(r_gnt & i_done)) | ~(|(r_gnt & i_req));

`ifdef CLK_REQ_ARBITER_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE:  r_cnt <= 8'd1;
        S_GRANT: begin
          if (!w_rel && r_cnt == 8'(MAX_HOLD))
            r_timeout <= 1'b1;
          else
            r_cnt <= r_cnt + 8'd1;
        end
        default: r_cnt <= 8'd0;
      endcase
    end
  end

  logic w_force;
  assign w_force   = (r_cnt == 8'(MAX_HOLD));
  assign o_timeout = r_timeout;
`else
  logic w_force;
  logic w_unused_hold;
  assign w_force       = 1'b0;
  assign w_unused_hold = (MAX_HOLD != 0);
  assign o_timeout     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_ptr   <= ID_W'(N_REQ - 1);
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_gnt   <= w_onehot;
            r_id    <= w_sel;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_rel || w_force) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_ptr   <= r_id;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt    = r_gnt;
  assign o_gnt_id = r_id;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_clk_req_arbiter.sv
// Table-driven bench for clk_req_arbiter with a scoreboard of expected outputs.
// Timeout vectors run only when CLK_REQ_ARBITER_TIMEOUT_EN is defined.
module tb_clk_req_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] o_gnt;
  logic [W-1:0] o_gnt_id;
  logic         o_busy;
  logic         o_timeout;

  clk_req_arbiter #(
    .N_REQ   (N),
    .ID_W    (W),
    .MAX_HOLD(4)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_done   (done),
    .o_gnt    (o_gnt),
    .o_gnt_id (o_gnt_id),
    .o_busy   (o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [W-1:0] id;
    logic         busy;
    logic         to;
  } vec_t;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] id;
    logic         busy;
    logic         to;
    int           tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, input logic [N-1:0] q,
                              input logic [N-1:0] d, input logic [N-1:0] g,
                              input logic [W-1:0] i, input logic b,
                              input logic t);
    vec_t v;
    v.rst_n = r;
    v.req   = q;
    v.done  = d;
    v.gnt   = g;
    v.id    = i;
    v.busy  = b;
    v.to    = t;
    tbl.push_back(v);
  endfunction

  task automatic check();
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    if (o_gnt !== e.gnt || o_gnt_id !== e.id || o_busy !== e.busy ||
        o_timeout !== e.to || !$onehot0(o_gnt)) begin
      n_bad++;
      $display("FAIL step%0d: got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
               e.tag, o_gnt, o_gnt_id, o_busy, o_timeout,
               e.gnt, e.id, e.busy, e.to);
    end
  endtask

  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    rst_n  = v.rst_n;
    req    = v.req;
    done   = v.done;
    e.gnt  = v.gnt;
    e.id   = v.id;
    e.busy = v.busy;
    e.to   = v.to;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    // reset
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // single requester, done after 3 grant cycles
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // reset, then all requesting: order 0,1,2,3,0
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b1111, 4'b0001, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0);
    add(1, 4'b1111, 4'b0010, 4'b0000, 1, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0100, 2, 1, 0);
    add(1, 4'b1111, 4'b0100, 4'b0000, 2, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 2, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b1000, 3, 1, 0);
    add(1, 4'b1111, 4'b1000, 4'b0000, 3, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 3, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b1111, 4'b0001, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // non-grantee done / req-drop ignored
    add(1, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
    add(1, 4'b0110, 4'b0010, 4'b0100, 2, 1, 0);
    add(1, 4'b0100, 4'b0010, 4'b0100, 2, 1, 0);
    add(1, 4'b0110, 4'b0100, 4'b0000, 2, 0, 0);
    add(1, 4'b0110, 4'b0000, 4'b0000, 2, 0, 0);
    // pointer at 2: search 3,0,1 -> 1
    add(1, 4'b0110, 4'b0000, 4'b0010, 1, 1, 0);
    // grantee drops request -> release
    add(1, 4'b0100, 4'b0000, 4'b0000, 1, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0);
    // reset mid-grant of requester 3
    add(1, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0);
    add(1, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

`ifdef CLK_REQ_ARBITER_TIMEOUT_EN
    begin
      vec_t v;
      v.rst_n = 1;
      v.req   = 4'b0010;
      v.done  = 4'b0000;
      v.gnt   = 4'b0010;
      v.id    = 1;
      v.busy  = 1;
      v.to    = 0;
      // stuck owner: 4 grant cycles, forced release with pulse
      for (int k = 0; k < 4; k++) apply(v, 100 + k);
      v.gnt = 4'b0000; v.busy = 0; v.to = 1;
      apply(v, 104);
      v.to = 0;
      apply(v, 105);
      // only requester is regranted; done on 4th cycle -> no pulse
      v.gnt = 4'b0010; v.busy = 1;
      for (int k = 0; k < 4; k++) apply(v, 106 + k);
      v.done = 4'b0010; v.gnt = 4'b0000; v.busy = 0;
      apply(v, 110);
      v.req = 4'b0000; v.done = 4'b0000;
      apply(v, 111);
      apply(v, 112);
    end
`else
    begin
      vec_t v;
      v.rst_n = 1;
      v.req   = 4'b0010;
      v.done  = 4'b0000;
      v.gnt   = 4'b0010;
      v.id    = 1;
      v.busy  = 1;
      v.to    = 0;
      // no timeout: grant held indefinitely
      for (int k = 0; k < 20; k++) apply(v, 100 + k);
      v.done = 4'b0010; v.gnt = 4'b0000; v.busy = 0;
      apply(v, 120);
      v.req = 4'b0000; v.done = 4'b0000;
      apply(v, 121);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_req_arbiter.md
# clk_req_arbiter

Round-robin arbiter sharing one downstream resource (e.g. a clocked datapath stage such as the state machine driven from a bus of per-source clock/enable lines) among `N_REQ` requesters. Each requester raises a request and holds it until it signals done; the block issues a registered one-hot grant, enforces a one-cycle idle gap between owners, and rotates priority fairly. An optional hold timeout reclaims the resource from a stuck owner.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16)
- `ID_W`, `$clog2(N_REQ)`, width of grant index
- `MAX_HOLD`, 15, max cycles in GRANT before forced release (timeout build only; 1..255)

Ports:
- `i_clk` input 1 — single clock; all logic on rising edge
- `i_rst_n` input 1 — reset, synchronous, active-low
- `i_req` input N_REQ — request per requester; level, held until granted and done
- `i_done` input N_REQ — owner finished; only bit of current grantee honoured
- `o_gnt` output N_REQ — one-hot grant, registered, all-zero when not granting
- `o_gnt_id` output ID_W — index of current/last grantee
- `o_busy` output 1 — high while in GRANT
- `o_timeout` output 1 — one-cycle pulse on forced release

## Operation
- FSM states: IDLE, GRANT, GAP.
- IDLE: if any `i_req` bit set, select first set bit searching from `ptr+1` upward modulo `N_REQ`; register `o_gnt`/`o_gnt_id`, go GRANT. Else stay.
- GRANT: hold grant. Release when `i_done[id]` = 1 or `i_req[id]` = 0 -> GAP. Done/req-drop of non-grantees ignored.
- GAP: `o_gnt` = 0, `o_busy` = 0, `ptr <= id`; always -> IDLE next cycle.
- Pointer `ptr` updates only on release; grantee becomes lowest priority.
- Requests arriving during GRANT/GAP are held by requester; no queuing inside block.
- Grantee re-requesting immediately after done competes with lowest priority.
- `o_gnt_id` holds last value outside GRANT.
- Exactly zero or one `o_gnt` bit high at every cycle; never a grant in GAP.

## Timing
- Reset (`i_rst_n` = 0 at an edge): state IDLE, `o_gnt` = 0, `o_gnt_id` = 0, `o_busy` = 0, `o_timeout` = 0, `ptr` = N_REQ-1 (requester 0 first), hold counter 0. Applies mid-GRANT: grant drops at that edge, no GAP, no timeout pulse.
- Grant latency: request sampled in IDLE at edge k -> `o_gnt` high after edge k (visible cycle k+1).
- Release: `i_done` sampled at edge m -> `o_gnt` low after edge m; GAP one cycle; next grant no earlier than visible cycle m+3 after IDLE sample.
- Minimum grant length 1 cycle (done asserted in first grant cycle honoured).
- Back-to-back ownership turnaround: 2 cycles with no grant (GAP + IDLE).

## Configuration
- `CLK_REQ_ARBITER_TIMEOUT_EN` defined: hold counter increments each GRANT cycle from 1; when counter = `MAX_HOLD` and no done/req-drop in that cycle, forced release -> GAP, `o_timeout` = 1 for the GAP cycle only. Done in same cycle as limit counts as normal release, no pulse. Counter clears on entering GRANT.
- Not defined: no counter, `MAX_HOLD` unused, `o_timeout` tied 0; grant held indefinitely until done/req-drop.

## Test plan
- Reset then `i_req`=4'b0001, `i_done[0]` pulse 3 cycles later -> `o_gnt`=0001 one cycle after req, 3 cycles held, then 0000 for 2 cycles; `o_gnt_id`=0.
- `i_req`=4'b1111 held, each grantee asserts done after 1 cycle -> grant order 0,1,2,3,0 with 2-cycle gaps; never two bits set.
- Grantee 2 active, requester 1 pulses `i_done` -> ignored, grant stays 0100 until `i_done[2]`.
- Assert `i_rst_n`=0 mid-GRANT of requester 3 -> `o_gnt`=0 next cycle, `o_busy`=0, `o_timeout`=0; next grant with `i_req`=1111 goes to 0.
- Timeout build, `MAX_HOLD`=4, `i_req`=0010 never done -> `o_gnt` high exactly 4 cycles, `o_timeout` one pulse, regrant to 1 after gap (only requester).
- Timeout build, done on the 4th cycle -> release with `o_timeout` staying 0.
